fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 101 ++++++++++
 tb/tb_fetch_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: IDLE/RUN/DONE program counter sequencer with jump table; FETCH_SEQ_LINK_EN adds call/return link register
module fetch_seq #(
   parameter int D        = 12,
   parameter int LUT_N    = 4,
   parameter int END_ADDR = 128,
   localparam int LW      = (LUT_N > 1) ? $clog2(LUT_N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   output logic          done,
   output logic          busy,
   output logic [D-1:0]  prog_ctr,
   input  logic          stall,
   input  logic          absjump_en,
   input  logic [LW-1:0] lut_sel,
   input  logic          reljump_en,
   input  logic [D-1:0]  rel_off,
   input  logic          lut_we,
   input  logic [LW-1:0] lut_waddr,
   input  logic [D-1:0]  lut_wdata,
   input  logic          call_en,
   input  logic          ret_en
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         r_state, w_state_nxt;
   logic [D-1:0]   r_pc, w_pc_nxt;
   logic [D-1:0]   r_lut [LUT_N];
   logic [D-1:0]   w_lut_rd, w_pc_inc, w_link;
   logic           w_ret, w_call, w_at_end, w_advance;

   assign w_lut_rd  = (32'(lut_sel) < LUT_N) ? r_lut[lut_sel] : '0;
   assign w_pc_inc  = r_pc + D'(1);
   assign w_at_end  = r_pc == D'(END_ADDR);
   assign w_advance = r_state == RUN && !w_at_end && !stall;

`ifdef FETCH_SEQ_LINK_EN
   logic [D-1:0] r_link;
   assign w_ret  = ret_en;
   assign w_call = call_en;
   assign w_link = r_link;
   // link register captures the return address on a call that is not overridden by a return
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_link <= '0;
      else if (w_advance && call_en && !ret_en) r_link <= w_pc_inc;
`else
   logic w_unused;
   assign w_unused = ^{call_en, ret_en};
   assign w_ret    = 1'b0;
   assign w_call   = 1'b0;
   assign w_link   = '0;
`endif

   // jump table write port, active in every state; out-of-range addresses are dropped
   always_ff @(posedge clk or negedge reset)
      if (!reset) for (int i = 0; i < LUT_N; i++) r_lut[i] <= '0;
      else if (lut_we && 32'(lut_waddr) < LUT_N) r_lut[lut_waddr] <= lut_wdata;

   // state and program counter registers
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_state <= IDLE;
         r_pc    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end

   // next state and next PC; end address wins over stall and jumps
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      case (r_state)
         IDLE: begin
            w_pc_nxt = '0;
            if (req) w_state_nxt = RUN;
         end
         RUN:
            if (w_at_end) w_state_nxt = DONE;
            else if (!stall)
               w_pc_nxt = w_ret ? w_link
                        : (absjump_en || w_call) ? w_lut_rd
                        : reljump_en ? r_pc + rel_off
                        : w_pc_inc;
         DONE:
            if (!req) begin
               w_state_nxt = IDLE;
               w_pc_nxt    = '0;
            end
         default: begin
            w_state_nxt = IDLE;
            w_pc_nxt    = '0;
         end
      endcase
   end

   assign done     = r_state == DONE;
   assign busy     = r_state == RUN;
   assign prog_ctr = r_pc;
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: table-driven and directed checks for fetch_seq (D=12, LUT_N=4, END_ADDR=128)
module tb_fetch_seq;
   localparam int D = 12;

   logic          clk = 0, reset = 0, req = 0, stall = 0, absjump_en = 0, reljump_en = 0;
   logic          lut_we = 0, call_en = 0, ret_en = 0;
   logic [1:0]    lut_sel = 0, lut_waddr = 0;
   logic [D-1:0]  rel_off = 0, lut_wdata = 0;
   logic [D-1:0]  prog_ctr;
   logic          done, busy;
   logic [D-1:0]  ret_pc;

   always #5 clk = ~clk;

   fetch_seq dut (
      .clk(clk), .reset(reset), .req(req), .done(done), .busy(busy), .prog_ctr(prog_ctr),
      .stall(stall), .absjump_en(absjump_en), .lut_sel(lut_sel), .reljump_en(reljump_en),
      .rel_off(rel_off), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
      .call_en(call_en), .ret_en(ret_en)
   );

   typedef struct {
      logic req, stall, abs;
      logic [1:0] sel;
      logic rel;
      logic [11:0] off;
      logic we;
      logic [1:0] wa;
      logic [11:0] wd;
      logic [11:0] pc;
      logic b, d;
   } vec_t;

   vec_t vt [27];
   int n_chk = 0, n_pass = 0;

   function automatic vec_t mk(logic rq, logic st, logic ab, logic [1:0] sl, logic rl, logic [11:0] of,
                               logic w, logic [1:0] wa, logic [11:0] wd, logic [11:0] pc, logic b, logic d);
      vec_t v;
      v.req = rq; v.stall = st; v.abs = ab; v.sel = sl; v.rel = rl; v.off = of;
      v.we = w; v.wa = wa; v.wd = wd; v.pc = pc; v.b = b; v.d = d;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic expect_out(input string nm, input logic [11:0] pc, input logic b, input logic d);
      chk({nm, " pc"}, 32'(prog_ctr), 32'(pc));
      chk({nm, " busy"}, 32'(busy), 32'(b));
      chk({nm, " done"}, 32'(done), 32'(d));
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in;
      req = 0; stall = 0; absjump_en = 0; lut_sel = 0; reljump_en = 0; rel_off = 0;
      lut_we = 0; lut_waddr = 0; lut_wdata = 0; call_en = 0; ret_en = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 expect_out("reset", 12'h000, 0, 0);
      #10 reset = 1;
      //          req st ab sel rl off     we wa wd       pc      b  d
      vt[0]  = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h000, 0, 0);
      vt[1]  = mk(0, 0, 0, 0, 0, 12'h000, 1, 2, 12'h040, 12'h000, 0, 0);
      vt[2]  = mk(1, 0, 1, 2, 0, 12'h000, 0, 0, 12'h000, 12'h000, 1, 0);
      vt[3]  = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h001, 1, 0);
      vt[4]  = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h002, 1, 0);
      vt[5]  = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h003, 1, 0);
      vt[6]  = mk(0, 0, 0, 0, 1, 12'hFFC, 0, 0, 12'h000, 12'hFFF, 1, 0);
      vt[7]  = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h000, 1, 0);
      vt[8]  = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h001, 1, 0);
      vt[9]  = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h002, 1, 0);
      vt[10] = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h003, 1, 0);
      vt[11] = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h004, 1, 0);
      vt[12] = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h005, 1, 0);
      vt[13] = mk(0, 0, 1, 2, 0, 12'h000, 1, 2, 12'h050, 12'h040, 1, 0);
      vt[14] = mk(0, 0, 1, 2, 1, 12'h005, 0, 0, 12'h000, 12'h050, 1, 0);
      vt[15] = mk(0, 0, 1, 3, 0, 12'h000, 0, 0, 12'h000, 12'h000, 1, 0);
      vt[16] = mk(0, 0, 0, 0, 1, 12'h00A, 0, 0, 12'h000, 12'h00A, 1, 0);
      vt[17] = mk(0, 1, 1, 2, 0, 12'h000, 0, 0, 12'h000, 12'h00A, 1, 0);
      vt[18] = mk(0, 1, 1, 2, 0, 12'h000, 0, 0, 12'h000, 12'h00A, 1, 0);
      vt[19] = mk(0, 1, 1, 2, 0, 12'h000, 0, 0, 12'h000, 12'h00A, 1, 0);
      vt[20] = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h00B, 1, 0);
      vt[21] = mk(0, 0, 0, 0, 1, 12'h073, 0, 0, 12'h000, 12'h07E, 1, 0);
      vt[22] = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h07F, 1, 0);
      vt[23] = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h080, 1, 0);
      vt[24] = mk(0, 0, 1, 2, 0, 12'h000, 0, 0, 12'h000, 12'h080, 0, 1);
      vt[25] = mk(1, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h080, 0, 1);
      vt[26] = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 12'h000, 0, 0);
      for (int i = 0; i < 27; i++) begin
         req = vt[i].req; stall = vt[i].stall; absjump_en = vt[i].abs; lut_sel = vt[i].sel;
         reljump_en = vt[i].rel; rel_off = vt[i].off;
         lut_we = vt[i].we; lut_waddr = vt[i].wa; lut_wdata = vt[i].wd;
         step;
         expect_out($sformatf("vec%0d", i), vt[i].pc, vt[i].b, vt[i].d);
      end
      clear_in;
      lut_we = 1; lut_waddr = 1; lut_wdata = 12'h100;
      step;
      clear_in; req = 1;
      step;
      expect_out("call_start", 12'h000, 1, 0);
      clear_in; reljump_en = 1; rel_off = 12'd20;
      step;
      expect_out("call_pc20", 12'h014, 1, 0);
      clear_in; call_en = 1; absjump_en = 1; lut_sel = 1;
      step;
      expect_out("call_tgt", 12'h100, 1, 0);
      clear_in;
      repeat (4) step;
      expect_out("call_body", 12'h104, 1, 0);
      ret_en = 1;
`ifdef FETCH_SEQ_LINK_EN
      ret_pc = 12'h015;
`else
      ret_pc = 12'h105;
`endif
      step;
      expect_out("ret", ret_pc, 1, 0);
      clear_in; reljump_en = 1; rel_off = 12'd50 - ret_pc;
      step;
      expect_out("pc50", 12'd50, 1, 0);
      clear_in;
      #3 reset = 0;
      #1 expect_out("async_rst", 12'h000, 0, 0);
      #2 reset = 1;
      step;
      expect_out("post_rst_idle", 12'h000, 0, 0);
      req = 1;
      step;
      expect_out("post_rst_req", 12'h000, 1, 0);
      clear_in; absjump_en = 1; lut_sel = 2;
      step;
      expect_out("lut_cleared", 12'h000, 1, 0);
      clear_in;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
